// File: rtl/encoder_velocity_sampler.sv
// Samples a wrapping encoder count once per PERIOD_CYCLES window and publishes the signed delta.
// Define ENC_VEL_SATURATE_EN to clamp out-of-range deltas instead of wrapping to VEL_WIDTH bits.
module encoder_velocity_sampler #(
    parameter int COUNT_WIDTH   = 15,
    parameter int VEL_WIDTH     = 12,
    parameter int PERIOD_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic                   rd_ack,
    output logic [VEL_WIDTH-1:0]   vel,
    output logic                   vel_valid,
    output logic                   overrun
);

    localparam int TIMER_W = $clog2(PERIOD_CYCLES);
    localparam logic [TIMER_W-1:0] TICK_AT = TIMER_W'(PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        PRIME,
        WAIT_TICK,
        CALC,
        PUBLISH
    } state_t;

    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [COUNT_WIDTH-1:0] prev_count_q, prev_count_d;
    logic [COUNT_WIDTH-1:0] cur_count_q, cur_count_d;
    logic [VEL_WIDTH-1:0]   delta_q, delta_d;
    logic [VEL_WIDTH-1:0]   vel_q, vel_d;
    logic                   vel_valid_q, vel_valid_d;
    logic                   overrun_q, overrun_d;

    logic                   tick;
    logic [COUNT_WIDTH-1:0] raw_delta;
    logic [VEL_WIDTH-1:0]   vel_next;

    assign tick      = (timer_q == TICK_AT);
    // Modular subtraction makes wrap-around of the upstream counter transparent.
    assign raw_delta = cur_count_q - prev_count_q;

`ifdef ENC_VEL_SATURATE_EN
    localparam logic signed [COUNT_WIDTH-1:0] VEL_MAX = COUNT_WIDTH'((1 << (VEL_WIDTH - 1)) - 1);
    localparam logic signed [COUNT_WIDTH-1:0] VEL_MIN = COUNT_WIDTH'(-(1 << (VEL_WIDTH - 1)));

    always_comb begin
        if ($signed(raw_delta) > VEL_MAX) begin
            vel_next = VEL_MAX[VEL_WIDTH-1:0];
        end else if ($signed(raw_delta) < VEL_MIN) begin
            vel_next = VEL_MIN[VEL_WIDTH-1:0];
        end else begin
            vel_next = VEL_WIDTH'(raw_delta);
        end
    end
`else
    assign vel_next = VEL_WIDTH'(raw_delta);
`endif

    always_comb begin
        state_d      = state_q;
        timer_d      = tick ? '0 : timer_q + 1'b1;
        prev_count_d = prev_count_q;
        cur_count_d  = cur_count_q;
        delta_d      = delta_q;
        vel_d        = vel_q;
        vel_valid_d  = vel_valid_q;
        overrun_d    = overrun_q;

        if (rd_ack && vel_valid_q) begin
            vel_valid_d = 1'b0;
        end

        case (state_q)
            PRIME: begin
                if (tick) begin
                    prev_count_d = count;
                    state_d      = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    cur_count_d = count;
                    state_d     = CALC;
                end
            end
            CALC: begin
                delta_d      = vel_next;
                prev_count_d = cur_count_q;
                state_d      = PUBLISH;
            end
            PUBLISH: begin
                // A publish overrides a coincident acknowledge; only an unread sample counts as overrun.
                vel_d       = delta_q;
                vel_valid_d = 1'b1;
                if (vel_valid_q && !rd_ack) begin
                    overrun_d = 1'b1;
                end
                state_d = WAIT_TICK;
            end
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PRIME;
            timer_q      <= '0;
            prev_count_q <= '0;
            cur_count_q  <= '0;
            delta_q      <= '0;
            vel_q        <= '0;
            vel_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            prev_count_q <= prev_count_d;
            cur_count_q  <= cur_count_d;
            delta_q      <= delta_d;
            vel_q        <= vel_d;
            vel_valid_q  <= vel_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign vel       = vel_q;
    assign vel_valid = vel_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/encoder_velocity_sampler.md
ENCODER_VELOCITY_SAMPLER -- requirements
Module: encoder_velocity_sampler

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 15, width of the input encoder count.
REQ-002 SHALL have parameter VEL_WIDTH, default 12, width of the signed velocity output (VEL_WIDTH <= COUNT_WIDTH).
REQ-003 SHALL have parameter PERIOD_CYCLES, default 1000, number of clk cycles per sample window (>= 4).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port count  input  COUNT_WIDTH  free-running, wrapping encoder position count from the upstream counter, same clock domain.
REQ-007 SHALL have port rd_ack  input  1  one-cycle consumer acknowledge of the current velocity sample.
REQ-008 SHALL have port vel  output  VEL_WIDTH  signed two's-complement count delta over the last window.
REQ-009 SHALL have port vel_valid  output  1  high while an unacknowledged sample is held in vel.
REQ-010 SHALL have port overrun  output  1  sticky flag: a new sample replaced an unacknowledged one.

Function
REQ-011 SHALL run a window timer counting 0..PERIOD_CYCLES-1 and wrapping; the cycle at PERIOD_CYCLES-1 is the tick.
REQ-012 SHALL use FSM states PRIME, WAIT_TICK, CALC, PUBLISH.
REQ-013 PRIME: on first tick after reset, latch count into prev_count, go to WAIT_TICK; no sample published.
REQ-014 WAIT_TICK: on tick, latch count into cur_count, go to CALC.
REQ-015 CALC (1 cycle): compute delta = cur_count - prev_count modulo 2^COUNT_WIDTH, interpreted signed; copy cur_count to prev_count; go to PUBLISH.
REQ-016 PUBLISH (1 cycle): load vel, set vel_valid, return to WAIT_TICK; vel updates exactly 2 cycles after tick.
REQ-017 Wrap-around: count transition 0x7FFF -> 0x0001 (COUNT_WIDTH=15) SHALL yield delta +2; 0x0001 -> 0x7FFF SHALL yield -2.
REQ-018 Truncation to VEL_WIDTH SHALL follow REQ-029/REQ-030.
REQ-019 rd_ack while vel_valid high SHALL clear vel_valid next cycle; vel holds its value.
REQ-020 rd_ack while vel_valid low SHALL be ignored.
REQ-021 PUBLISH while vel_valid high SHALL overwrite vel, keep vel_valid high, set overrun.
REQ-022 PUBLISH and rd_ack in the same cycle: new sample wins; vel_valid stays high; overrun NOT set.
REQ-023 overrun SHALL clear only on reset.
REQ-024 Timer SHALL keep running through CALC/PUBLISH; window length is exactly PERIOD_CYCLES.

Reset
REQ-025 reset high SHALL force: state PRIME, timer 0, prev_count/cur_count 0, vel 0, vel_valid 0, overrun 0.
REQ-026 reset asserted mid-window or in CALC/PUBLISH SHALL abort the sample; nothing published.
REQ-027 After reset deassertion the first valid sample SHALL appear 2 cycles after the second tick.
REQ-028 reset SHALL take priority over rd_ack and all FSM transitions.

Configuration
REQ-029 Macro ENC_VEL_SATURATE_EN defined: delta outside VEL_WIDTH signed range SHALL clamp to max positive / min negative (2047 / -2048 at default).
REQ-030 Macro ENC_VEL_SATURATE_EN undefined: vel SHALL be the low VEL_WIDTH bits of delta (wrapping), no clamp logic present.

Verification
REQ-031 Reset, count static at 100, 3 windows -> vel_valid first high 2 cycles after 2nd tick, vel=0, overrun=0.
REQ-032 count advances +37 per window, rd_ack each sample -> vel=37 every window, overrun stays 0.
REQ-033 count 0x7FFE at tick N, 0x0003 at tick N+1 -> vel=+5; reverse sequence -> vel=-5.
REQ-034 delta +3000 with ENC_VEL_SATURATE_EN -> vel=2047; without -> vel=-1096 (3000 mod 4096 signed).
REQ-035 Two samples with no rd_ack -> second vel published, overrun=1; rd_ack coincident with PUBLISH -> vel_valid=1, overrun=0.
REQ-036 reset pulsed during CALC -> no vel_valid that window; vel=0; re-prime on next tick.
